instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 54 +++++
 rtl/instruction_fetch_unit.sv | 88 ++++++++
 tb/tb_instruction_fetch_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Purpose: shared types and constants for the instruction fetch unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

   // One prefetched instruction together with the byte address it came from.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   localparam logic [31:0] PC_STEP          = 32'd4;
   localparam logic [31:0] PC_READ_OFFSET   = 32'd8;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Purpose: prefetch buffer holding fetched {pc, instr} entries in program order.
// Latency: an entry pushed at edge N is visible at head right after edge N.
// Backpressure: full blocks push unless a pop happens in the same cycle.
//
// Ports: clk/reset (async active-low); push, pop, flush (flush wins and
// empties the buffer); push_entry; full, empty; head (entry at read pointer).
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t push_entry,
   output logic         full,
   output logic         empty,
   output fetch_entry_t head
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   fetch_entry_t     r_mem [DEPTH];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
   end

   // Storage needs no reset: empty hides stale contents from the consumer.
   always_ff @(posedge clk) begin
      if (push && !flush) r_mem[r_wr_ptr[IDX_W-1:0]] <= push_entry;
   end

   assign full  = (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]) &&
                  (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]);
   assign empty = (r_wr_ptr == r_rd_ptr);
   assign head  = r_mem[r_rd_ptr[IDX_W-1:0]];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Purpose: sequential instruction prefetch with redirect, feeding decode.
// Latency: fetch-to-valid one cycle; a redirect costs exactly one empty cycle.
// Backpressure: instr_ready=0 fills the buffer, then fetch_pc stalls.
//
// Ports: clk, reset (async active-low); imem_a/imem_rd combinational memory
// port; redirect/redirect_pc flush and retarget fetch; instr, instr_pc,
// instr_pc8, instr_valid present the buffer head; instr_ready pops it.
module instruction_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_a,
   input  logic [31:0] imem_rd,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [31:0] instr_pc8,
   output logic        instr_valid,
   input  logic        instr_ready
);

   logic [31:0]  r_fetch_pc;
   fetch_entry_t r_last;
   fetch_entry_t w_push_entry;
   fetch_entry_t w_head;
   fetch_entry_t w_out;
   logic         w_push;
   logic         w_pop;
   logic         w_full;
   logic         w_empty;
   logic         w_unused;

   // Redirect outranks both push and pop; a pop frees a slot for a same-cycle push.
   assign w_pop  = !w_empty && instr_ready && !redirect;
   assign w_push = !redirect && (!w_full || w_pop);

   assign w_push_entry.pc    = r_fetch_pc;
   assign w_push_entry.instr = imem_rd;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_fetch_pc <= {RESET_PC[31:2], 2'b00};
      end else if (redirect) begin
         r_fetch_pc <= {redirect_pc[31:2], 2'b00};
      end else if (w_push) begin
         r_fetch_pc <= r_fetch_pc + PC_STEP;
      end
   end

   // Remember the last valid head so outputs hold steady while the buffer is empty.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_last <= '0;
      end else if (!w_empty) begin
         r_last <= w_head;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (w_push),
      .pop        (w_pop),
      .flush      (redirect),
      .push_entry (w_push_entry),
      .full       (w_full),
      .empty      (w_empty),
      .head       (w_head)
   );

   assign w_out       = w_empty ? r_last : w_head;
   assign imem_a      = r_fetch_pc;
   assign instr       = w_out.instr;
   assign instr_pc    = w_out.pc;
   assign instr_pc8   = w_out.pc + PC_READ_OFFSET;
   assign instr_valid = !w_empty;

   // Redirect targets are word aligned; the low address bits are dropped.
   assign w_unused = ^redirect_pc[1:0];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 4;

   logic        clk;
   logic        reset;
   logic [31:0] imem_a;
   logic [31:0] imem_rd;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [31:0] instr_pc8;
   logic        instr_valid;
   logic        instr_ready;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: queue of buffered fetch addresses plus the next fetch address.
   logic [31:0] mq[$];
   logic [31:0] mpc;

   instruction_fetch_unit #(
      .RESET_PC (RESET_PC),
      .DEPTH    (DEPTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_a      (imem_a),
      .imem_rd     (imem_rd),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_pc8   (instr_pc8),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready)
   );

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return 32'hE000_0000 + (a >> 2);
   endfunction

   // Memory: word index i holds E000_0000 + i.
   assign imem_rd = word_at(imem_a);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   task automatic model_reset();
      mq.delete();
      mpc = RESET_PC;
   endtask

   // Advance one clock: update the model from the inputs seen at the edge,
   // then return at the following falling edge where outputs are sampled.
   task automatic cycle();
      bit do_pop;
      bit do_push;
      @(posedge clk);
      if (redirect) begin
         mq.delete();
         mpc = {redirect_pc[31:2], 2'b00};
      end else begin
         do_pop  = (mq.size() > 0) && instr_ready;
         do_push = (mq.size() < DEPTH) || do_pop;
         if (do_pop) void'(mq.pop_front());
         if (do_push) begin
            mq.push_back(mpc);
            mpc = mpc + 32'd4;
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      instr_ready = 1'b0;
      repeat (2) @(negedge clk);
      model_reset();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      instr_ready = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++; if (imem_a !== RESET_PC) begin n_fail++; $display("FAIL reset_imem_a: got %h want %h", imem_a, RESET_PC); end
      n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
      n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", instr); end
      n_checks++; if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL reset_instr_pc: got %h want 0", instr_pc); end
      n_checks++; if (instr_pc8 !== 32'h8) begin n_fail++; $display("FAIL reset_instr_pc8: got %h want 8", instr_pc8); end
   endtask

   task automatic test_stream();
      do_reset();
      instr_ready = 1'b1;
      n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL stream_first_cycle_valid: got %b want 0", instr_valid); end
      for (int i = 0; i < 8; i++) begin
         cycle();
         n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b want 1", i, instr_valid); end
         n_checks++; if (instr_pc !== 32'(4 * i)) begin n_fail++; $display("FAIL stream_pc[%0d]: got %h want %h", i, instr_pc, 32'(4 * i)); end
         n_checks++; if (instr !== 32'hE000_0000 + 32'(i)) begin n_fail++; $display("FAIL stream_instr[%0d]: got %h want %h", i, instr, 32'hE000_0000 + 32'(i)); end
         n_checks++; if (instr_pc8 !== 32'(4 * i + 8)) begin n_fail++; $display("FAIL stream_pc8[%0d]: got %h want %h", i, instr_pc8, 32'(4 * i + 8)); end
      end
   endtask

   // Stall fills the buffer, then release drains in order; continues into full-flow.
   task automatic test_stall();
      do_reset();
      instr_ready = 1'b0;
      repeat (10) cycle();
      n_checks++; if (imem_a !== 32'h10) begin n_fail++; $display("FAIL stall_imem_a: got %h want 00000010", imem_a); end
      n_checks++; if (instr_pc !== 32'h0 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL stall_head: got pc %h v %b want 0 v 1", instr_pc, instr_valid); end
      instr_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * i)) begin n_fail++; $display("FAIL drain[%0d]: got pc %h v %b want %h v 1", i, instr_pc, instr_valid, 32'(4 * i)); end
         cycle();
      end
   endtask

   task automatic test_full_flow();
      for (int k = 0; k < 6; k++) begin
         cycle();
         n_checks++; if (instr_pc !== 32'(20 + 4 * k)) begin n_fail++; $display("FAIL full_flow_pc[%0d]: got %h want %h", k, instr_pc, 32'(20 + 4 * k)); end
         n_checks++; if (imem_a !== 32'(36 + 4 * k)) begin n_fail++; $display("FAIL full_flow_occupancy[%0d]: imem_a got %h want %h", k, imem_a, 32'(36 + 4 * k)); end
      end
   endtask

   task automatic test_redirect();
      do_reset();
      instr_ready = 1'b0;
      repeat (3) cycle();
      n_checks++; if (imem_a !== 32'hC) begin n_fail++; $display("FAIL redirect_prefill: imem_a got %h want 0000000c", imem_a); end
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0043;
      cycle();
      redirect = 1'b0;
      n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL redirect_bubble: valid got %b want 0", instr_valid); end
      n_checks++; if (imem_a !== 32'h40) begin n_fail++; $display("FAIL redirect_imem_a: got %h want 00000040", imem_a); end
      cycle();
      n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL redirect_target_valid: got %b want 1", instr_valid); end
      n_checks++; if (instr_pc !== 32'h40) begin n_fail++; $display("FAIL redirect_target_pc: got %h want 00000040", instr_pc); end
      n_checks++; if (instr_pc8 !== 32'h48) begin n_fail++; $display("FAIL redirect_target_pc8: got %h want 00000048", instr_pc8); end
      n_checks++; if (instr !== 32'hE000_0010) begin n_fail++; $display("FAIL redirect_target_instr: got %h want e0000010", instr); end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_pc [3];
      exp_pc[0] = 32'hFFFF_FFF8;
      exp_pc[1] = 32'hFFFF_FFFC;
      exp_pc[2] = 32'h0000_0000;
      instr_ready = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFF8;
      cycle();
      redirect = 1'b0;
      n_checks++; if (imem_a !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL wrap_imem_a: got %h want fffffff8", imem_a); end
      for (int i = 0; i < 3; i++) begin
         cycle();
         n_checks++; if (instr_valid !== 1'b1 || instr_pc !== exp_pc[i]) begin n_fail++; $display("FAIL wrap_pc[%0d]: got %h v %b want %h", i, instr_pc, instr_valid, exp_pc[i]); end
         n_checks++; if (instr_pc8 !== exp_pc[i] + 32'd8) begin n_fail++; $display("FAIL wrap_pc8[%0d]: got %h want %h", i, instr_pc8, exp_pc[i] + 32'd8); end
         n_checks++; if (instr !== word_at(exp_pc[i])) begin n_fail++; $display("FAIL wrap_instr[%0d]: got %h want %h", i, instr, word_at(exp_pc[i])); end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      instr_ready = 1'b0;
      repeat (2) cycle();
      n_checks++; if (instr_valid !== 1'b1 || imem_a !== 32'h8) begin n_fail++; $display("FAIL areset_prefill: v %b imem_a %h want 1 / 00000008", instr_valid, imem_a); end
      #2 reset = 1'b0;
      #1;
      n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %b want 0 without a clock edge", instr_valid); end
      n_checks++; if (imem_a !== RESET_PC) begin n_fail++; $display("FAIL areset_imem_a: got %h want %h", imem_a, RESET_PC); end
      @(negedge clk);
      model_reset();
      reset       = 1'b1;
      instr_ready = 1'b1;
      cycle();
      n_checks++; if (instr_valid !== 1'b1 || instr_pc !== RESET_PC) begin n_fail++; $display("FAIL areset_first_pc: got %h v %b want %h v 1", instr_pc, instr_valid, RESET_PC); end
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 600; n++) begin
         instr_ready = ($urandom_range(0, 9) < 6);
         redirect    = ($urandom_range(0, 19) == 0);
         redirect_pc = $urandom;
         cycle();
         n_checks++; if (instr_valid !== (mq.size() > 0)) begin n_fail++; $display("FAIL rand_valid[%0d]: got %b want %b", n, instr_valid, mq.size() > 0); end
         n_checks++; if (imem_a !== mpc) begin n_fail++; $display("FAIL rand_imem_a[%0d]: got %h want %h", n, imem_a, mpc); end
         if (mq.size() > 0) begin
            n_checks++; if (instr_pc !== mq[0]) begin n_fail++; $display("FAIL rand_pc[%0d]: got %h want %h", n, instr_pc, mq[0]); end
            n_checks++; if (instr !== word_at(mq[0])) begin n_fail++; $display("FAIL rand_instr[%0d]: got %h want %h", n, instr, word_at(mq[0])); end
            n_checks++; if (instr_pc8 !== mq[0] + 32'd8) begin n_fail++; $display("FAIL rand_pc8[%0d]: got %h want %h", n, instr_pc8, mq[0] + 32'd8); end
         end
      end
      redirect = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_full_flow();
      test_redirect();
      test_wrap();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
